correlation_acc: RTL and testbench

Parametrised 2-input spectral correlator with vector integration. For two streamed complex spectra it computes the auto-powers |X1|², |X2|² and the cross-product X1·conj(X2) per frequency channel. Each of the four quantities is accumulated over a run-time programmable number of spectra, and one integrated vector is emitted per integration period. The block sits after the FFT/channeliser, in place of the per-sample correlation multipliers, and feeds the readout/packetiser.

---
 rtl/correlation_acc.sv | 200 ++++++++++++++++++++
 tb/tb_correlation_acc.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/correlation_acc.sv
`default_nettype none
// ============================================================================
//  Module      : correlation_acc
//  Description : Two-input spectral correlator. Per channel it integrates
//                |X1|^2, |X2|^2 and X1*conj(X2) over acc_len spectra.
//  Revision    : 1.0  initial release
// ============================================================================
module correlation_acc #(
    parameter int DIN_WIDTH     = 18,
    parameter int VECTOR_LEN    = 64,
    parameter int ACC_WIDTH     = 48,
    parameter int ACC_LEN_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic signed [DIN_WIDTH-1:0]     din1_re,
    input  logic signed [DIN_WIDTH-1:0]     din1_im,
    input  logic signed [DIN_WIDTH-1:0]     din2_re,
    input  logic signed [DIN_WIDTH-1:0]     din2_im,
    input  logic                            din_valid,
    input  logic                            sync_in,
    input  logic [ACC_LEN_WIDTH-1:0]        acc_len,
    output logic [ACC_WIDTH-1:0]            r11,
    output logic [ACC_WIDTH-1:0]            r22,
    output logic signed [ACC_WIDTH-1:0]     corr_re,
    output logic signed [ACC_WIDTH-1:0]     corr_im,
    output logic [$clog2(VECTOR_LEN)-1:0]   dout_ch,
    output logic                            dout_valid,
    output logic                            dout_last,
    output logic                            resync
);

    localparam int C_CH_W = $clog2(VECTOR_LEN);
    localparam int C_PW   = 2 * DIN_WIDTH;
    localparam int C_SW   = 2 * DIN_WIDTH + 1;
    localparam logic [C_CH_W-1:0] C_CH_LAST = C_CH_W'(VECTOR_LEN - 1);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    // ------------------------------------------------------------------
    // Channel / spectrum sequencing
    // ------------------------------------------------------------------
    state_t                   r_state;
    logic [C_CH_W-1:0]        r_ch;
    logic [ACC_LEN_WIDTH-1:0] r_spec;
    logic [ACC_LEN_WIDTH-1:0] r_acc_len_q;

    logic                     w_take;
    logic                     w_restart;
    logic [C_CH_W-1:0]        w_ch;
    logic [ACC_LEN_WIDTH-1:0] w_spec;
    logic [ACC_LEN_WIDTH-1:0] w_alen;
    logic                     w_first;
    logic                     w_last;

    always_comb begin
        w_take    = din_valid && (r_state == S_RUN || sync_in);
        // Start of a fresh integration: leaving IDLE, or a misplaced sync
        w_restart = din_valid && sync_in && (r_state == S_IDLE || r_ch != '0);
        w_ch      = w_restart ? '0 : r_ch;
        w_spec    = w_restart ? '0 : r_spec;
        w_alen    = r_acc_len_q;
        if (w_ch == '0 && w_spec == '0)
            w_alen = (acc_len == '0) ? ACC_LEN_WIDTH'(1) : acc_len;
        w_first   = (w_spec == '0);
        w_last    = (w_spec == w_alen - ACC_LEN_WIDTH'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ch        <= '0;
            r_spec      <= '0;
            r_acc_len_q <= ACC_LEN_WIDTH'(1);
            resync      <= 1'b0;
        end else begin
            resync <= w_restart && (r_state == S_RUN);
            if (w_take) begin
                r_state     <= S_RUN;
                r_acc_len_q <= w_alen;
                r_ch        <= w_ch + C_CH_W'(1);
                if (w_ch == C_CH_LAST)
                    r_spec <= w_last ? '0 : w_spec + ACC_LEN_WIDTH'(1);
                else
                    r_spec <= w_spec;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pipeline valids (cleared asynchronously so no partial output escapes)
    // ------------------------------------------------------------------
    logic r_s1_valid, r_s2_valid, r_s3_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_take;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic signed [DIN_WIDTH-1:0] r_s1_re1, r_s1_im1, r_s1_re2, r_s1_im2;
    logic                        r_s1_first, r_s1_last;
    logic [C_CH_W-1:0]           r_s1_ch;

    logic signed [C_PW-1:0]      r_s2_rr1, r_s2_ii1, r_s2_rr2, r_s2_ii2;
    logic signed [C_PW-1:0]      r_s2_r1r2, r_s2_i1i2, r_s2_i1r2, r_s2_r1i2;
    logic                        r_s2_first, r_s2_last;
    logic [C_CH_W-1:0]           r_s2_ch;
    logic [4*ACC_WIDTH-1:0]      r_s2_st;

    logic signed [C_SW-1:0]      r_s3_p11, r_s3_p22, r_s3_pre, r_s3_pim;
    logic                        r_s3_first, r_s3_last;
    logic [C_CH_W-1:0]           r_s3_ch;
    logic [4*ACC_WIDTH-1:0]      r_s3_st;

    // Packed per-channel entry: {r11, r22, corr_re, corr_im}
    logic [4*ACC_WIDTH-1:0]      r_mem [VECTOR_LEN];

    always_ff @(posedge clk) begin
        r_s1_re1   <= din1_re;
        r_s1_im1   <= din1_im;
        r_s1_re2   <= din2_re;
        r_s1_im2   <= din2_im;
        r_s1_first <= w_first;
        r_s1_last  <= w_last;
        r_s1_ch    <= w_ch;

        r_s2_rr1   <= C_PW'(r_s1_re1) * C_PW'(r_s1_re1);
        r_s2_ii1   <= C_PW'(r_s1_im1) * C_PW'(r_s1_im1);
        r_s2_rr2   <= C_PW'(r_s1_re2) * C_PW'(r_s1_re2);
        r_s2_ii2   <= C_PW'(r_s1_im2) * C_PW'(r_s1_im2);
        r_s2_r1r2  <= C_PW'(r_s1_re1) * C_PW'(r_s1_re2);
        r_s2_i1i2  <= C_PW'(r_s1_im1) * C_PW'(r_s1_im2);
        r_s2_i1r2  <= C_PW'(r_s1_im1) * C_PW'(r_s1_re2);
        r_s2_r1i2  <= C_PW'(r_s1_re1) * C_PW'(r_s1_im2);
        r_s2_first <= r_s1_first;
        r_s2_last  <= r_s1_last;
        r_s2_ch    <= r_s1_ch;
        r_s2_st    <= r_mem[r_s1_ch];

        r_s3_p11   <= C_SW'(r_s2_rr1)  + C_SW'(r_s2_ii1);
        r_s3_p22   <= C_SW'(r_s2_rr2)  + C_SW'(r_s2_ii2);
        r_s3_pre   <= C_SW'(r_s2_r1r2) + C_SW'(r_s2_i1i2);
        r_s3_pim   <= C_SW'(r_s2_i1r2) - C_SW'(r_s2_r1i2);
        r_s3_first <= r_s2_first;
        r_s3_last  <= r_s2_last;
        r_s3_ch    <= r_s2_ch;
        r_s3_st    <= r_s2_st;
    end

    logic [ACC_WIDTH-1:0] w_sum11, w_sum22, w_sumre, w_sumim;
    logic [4*ACC_WIDTH-1:0] w_base;

    always_comb begin
        // The first spectrum overwrites, so stale memory never leaks in
        w_base  = r_s3_first ? '0 : r_s3_st;
        w_sum11 = w_base[4*ACC_WIDTH-1:3*ACC_WIDTH] + ACC_WIDTH'(r_s3_p11);
        w_sum22 = w_base[3*ACC_WIDTH-1:2*ACC_WIDTH] + ACC_WIDTH'(r_s3_p22);
        w_sumre = w_base[2*ACC_WIDTH-1:ACC_WIDTH]   + ACC_WIDTH'(r_s3_pre);
        w_sumim = w_base[ACC_WIDTH-1:0]             + ACC_WIDTH'(r_s3_pim);
    end

    always_ff @(posedge clk) begin
        if (r_s3_valid && !r_s3_last)
            r_mem[r_s3_ch] <= {w_sum11, w_sum22, w_sumre, w_sumim};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r11        <= '0;
            r22        <= '0;
            corr_re    <= '0;
            corr_im    <= '0;
            dout_ch    <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            dout_valid <= r_s3_valid && r_s3_last;
            dout_last  <= r_s3_valid && r_s3_last && (r_s3_ch == C_CH_LAST);
            if (r_s3_valid && r_s3_last) begin
                r11     <= w_sum11;
                r22     <= w_sum22;
                corr_re <= w_sumre;
                corr_im <= w_sumim;
                dout_ch <= r_s3_ch;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_correlation_acc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_correlation_acc
//  Description : Randomised self-checking bench with a per-sample integration
//                model and latency-tagged expected-output queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_correlation_acc;

    localparam int    VL   = 8;
    localparam longint MASK = 64'h0000_FFFF_FFFF_FFFF;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [17:0] din1_re = '0, din1_im = '0, din2_re = '0, din2_im = '0;
    logic               din_valid = 1'b0, sync_in = 1'b0;
    logic [15:0]        acc_len = 16'd1;
    logic [47:0]        r11, r22, corr_re, corr_im;
    logic [2:0]         dout_ch;
    logic               dout_valid, dout_last, resync;

    correlation_acc #(
        .DIN_WIDTH(18), .VECTOR_LEN(VL), .ACC_WIDTH(48), .ACC_LEN_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .din1_re(din1_re), .din1_im(din1_im), .din2_re(din2_re), .din2_im(din2_im),
        .din_valid(din_valid), .sync_in(sync_in), .acc_len(acc_len),
        .r11(r11), .r22(r22), .corr_re(corr_re), .corr_im(corr_im),
        .dout_ch(dout_ch), .dout_valid(dout_valid), .dout_last(dout_last),
        .resync(resync)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;
    bit mon_en  = 1'b0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        longint r11, r22, cre, cim;
        int     ch;
        bit     last;
        int     at;
    } exp_t;

    exp_t   exp_q[$];
    int     rs_q[$];
    bit     m_run = 1'b0;
    int     m_ch = 0, m_nspec = 0, m_alen = 1;
    longint a11[VL], a22[VL], are[VL], aim[VL];

    task automatic model_reset();
        m_run = 1'b0;
        m_ch = 0;
        m_nspec = 0;
        exp_q.delete();
        rs_q.delete();
    endtask

    task automatic model_sample(input bit s, input logic signed [17:0] a, b, c, d);
        longint xa, xb, xc, xd, p11, p22, pre, pim;
        exp_t   e;
        xa = longint'(a); xb = longint'(b); xc = longint'(c); xd = longint'(d);
        p11 = xa*xa + xb*xb;
        p22 = xc*xc + xd*xd;
        pre = xa*xc + xb*xd;
        pim = xb*xc - xa*xd;
        if (m_run || s) begin
            if (m_run && s && m_ch != 0) rs_q.push_back(edge_n + 1);
            if (!m_run || (s && m_ch != 0)) begin
                m_run = 1'b1; m_ch = 0; m_nspec = 0;
            end
            if (m_ch == 0 && m_nspec == 0) m_alen = (acc_len == 16'd0) ? 1 : int'(acc_len);
            if (m_nspec == 0) begin
                a11[m_ch] = p11; a22[m_ch] = p22; are[m_ch] = pre; aim[m_ch] = pim;
            end else begin
                a11[m_ch] += p11; a22[m_ch] += p22; are[m_ch] += pre; aim[m_ch] += pim;
            end
            if (m_nspec == m_alen - 1) begin
                e.r11 = a11[m_ch]; e.r22 = a22[m_ch]; e.cre = are[m_ch]; e.cim = aim[m_ch];
                e.ch = m_ch; e.last = (m_ch == VL - 1); e.at = edge_n + 4;
                exp_q.push_back(e);
            end
            m_ch++;
            if (m_ch == VL) begin
                m_ch = 0;
                m_nspec++;
                if (m_nspec == m_alen) m_nspec = 0;
            end
        end
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        bit   er;
        exp_t e;
        if (mon_en) begin
            er = 1'b0;
            if (rs_q.size() > 0 && rs_q[0] == edge_n) begin
                er = 1'b1;
                void'(rs_q.pop_front());
            end
            check_eq("resync", 64'(resync), 64'(er));
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("stray_valid", 64'(dout_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check_eq("latency",   64'(edge_n),    64'(e.at));
                    check_eq("dout_ch",   64'(dout_ch),   64'(e.ch));
                    check_eq("dout_last", 64'(dout_last), 64'(e.last));
                    check_eq("r11",       64'(r11),       e.r11 & MASK);
                    check_eq("r22",       64'(r22),       e.r22 & MASK);
                    check_eq("corr_re",   64'(corr_re),   e.cre & MASK);
                    check_eq("corr_im",   64'(corr_im),   e.cim & MASK);
                end
            end else begin
                check_eq("last_idle", 64'(dout_last), 64'(0));
                if (exp_q.size() > 0 && exp_q[0].at < edge_n) begin
                    check_eq("missing_out", 64'(dout_valid), 64'(1));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input bit s, input logic signed [17:0] a, b, c, d);
        @(posedge clk);
        #1;
        din_valid = v; sync_in = s;
        din1_re = a; din1_im = b; din2_re = c; din2_im = d;
        if (v) model_sample(s, a, b, c, d);
    endtask

    function automatic logic signed [17:0] rnd_comp();
        if ($urandom_range(0, 7) == 0) return 18'sh20000;
        return 18'($urandom);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    // nvalid samples; sync on every 8th valid sample counted from the call
    task automatic run(input int nvalid, input int duty, input bit rnd_data);
        int k;
        bit v, s;
        logic signed [17:0] a, b, c, d;
        k = 0;
        while (k < nvalid) begin
            v = (duty >= 100) || ($urandom_range(0, 99) < duty);
            if (rnd_data) begin
                a = rnd_comp(); b = rnd_comp(); c = rnd_comp(); d = rnd_comp();
                if (k == 0) begin
                    a = 18'sh20000; b = 18'sh20000; c = 18'sh20000; d = 18'sh20000;
                end
            end else begin
                a = 18'sd3; b = 18'sd4; c = 18'sd1; d = -18'sd2;
            end
            s = v ? (k % VL == 0) : ($urandom_range(0, 1) == 1);
            drive(v, s, a, b, c, d);
            if (v) k++;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_r11"},   64'(r11),        64'(0));
        check_eq({tag, "_r22"},   64'(r22),        64'(0));
        check_eq({tag, "_cre"},   64'(corr_re),    64'(0));
        check_eq({tag, "_cim"},   64'(corr_im),    64'(0));
        check_eq({tag, "_ch"},    64'(dout_ch),    64'(0));
        check_eq({tag, "_valid"}, 64'(dout_valid), 64'(0));
        check_eq({tag, "_last"},  64'(dout_last),  64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset");
        mon_en = 1'b1;

        // Free-running valid with no sync: must stay idle
        for (int i = 0; i < 200; i++) drive(1'b1, 1'b0, 18'sd5, 18'sd7, -18'sd9, 18'sd11);
        idle(6);
        @(negedge clk);
        check_zero_outputs("idle");

        // Basic constant integration over 4 spectra, two periods
        acc_len = 16'd4;
        run(64, 100, 1'b0);
        idle(10);
        @(negedge clk);
        check_eq("basic_r11", 64'(r11),     64'(100));
        check_eq("basic_r22", 64'(r22),     64'(20));
        check_eq("basic_cre", 64'(corr_re), longint'(-20) & MASK);
        check_eq("basic_cim", 64'(corr_im), 64'(40));

        // Pass-through integration lengths
        acc_len = 16'd1;
        run(24, 100, 1'b1);
        acc_len = 16'd0;
        run(24, 100, 1'b1);
        idle(10);

        // Gapped full-scale input
        acc_len = 16'd3;
        run(48, 50, 1'b1);
        idle(10);

        // Resync at channel 5 of spectrum 2
        acc_len = 16'd4;
        run(21, 100, 1'b1);
        run(32, 70, 1'b1);
        idle(10);

        // Asynchronous reset during spectrum 1, then restart
        run(12, 100, 1'b1);
        #2 rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        din_valid = 1'b0;
        run(32, 100, 1'b1);
        idle(10);

        check_eq("drain_empty", 64'(exp_q.size()), 64'(0));
        check_eq("resync_empty", 64'(rs_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
